// File: rtl/imm_extend_unit.sv
// imm_extend_unit: pipelined operand extension stage with a 2-entry skid buffer.
// Modes: ZERO, SIGN, UPPER, PASS and, when IMMEXT_LOAD_EN is defined, the
// LB/LBU/LH/LHU load-data extraction. With IMMEXT_LOAD_EN undefined, modes 4-7
// return data 0 and err 1.
`timescale 1ns/1ps
module imm_extend_unit #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_mode,
  input  logic [OUT_W-1:0] in_data,
  input  logic [1:0]       in_off,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} occ_e;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  localparam logic [2:0] ModeZero  = 3'd0;
  localparam logic [2:0] ModeSign  = 3'd1;
  localparam logic [2:0] ModeUpper = 3'd2;
  localparam logic [2:0] ModePass  = 3'd3;

  occ_e   state_q, state_d;
  entry_t head_q, tail_q;
  entry_t res;

  logic push, pop;
  logic load_head_new, load_head_tail, load_tail_new;

  logic [IN_W-1:0] imm;
  assign imm = in_data[IN_W-1:0];

`ifdef IMMEXT_LOAD_EN
  localparam logic [2:0] ModeLb  = 3'd4;
  localparam logic [2:0] ModeLbu = 3'd5;
  localparam logic [2:0] ModeLh  = 3'd6;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Little-endian byte/half selection from the low load word.
  always_comb begin
    ld_byte = 8'h00;
    case (in_off)
      2'd0:    ld_byte = in_data[7:0];
      2'd1:    ld_byte = in_data[15:8];
      2'd2:    ld_byte = in_data[23:16];
      default: ld_byte = in_data[31:24];
    endcase
    ld_half = in_off[1] ? in_data[31:16] : in_data[15:0];
  end
`else
  // Offset only matters for load modes, which are compiled out here.
  logic unused_off;
  assign unused_off = ^in_off;
`endif

  // Combinational extension of the incoming request.
  always_comb begin
    res.data = '0;
    res.tag  = in_tag;
    res.err  = 1'b0;
    case (in_mode)
      ModeZero:  res.data = {{(OUT_W-IN_W){1'b0}}, imm};
      ModeSign:  res.data = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
      ModeUpper: res.data = {imm, {(OUT_W-IN_W){1'b0}}};
      ModePass:  res.data = in_data;
`ifdef IMMEXT_LOAD_EN
      ModeLb:    res.data = {{(OUT_W-8){ld_byte[7]}}, ld_byte};
      ModeLbu:   res.data = {{(OUT_W-8){1'b0}}, ld_byte};
      ModeLh: begin
        if (in_off[0]) res.err = 1'b1;
        else           res.data = {{(OUT_W-16){ld_half[15]}}, ld_half};
      end
      default: begin
        if (in_off[0]) res.err = 1'b1;
        else           res.data = {{(OUT_W-16){1'b0}}, ld_half};
      end
`else
      default:   res.err = 1'b1;
`endif
    endcase
  end

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StEmpty;
    else        state_q <= state_d;
  end

  // Occupancy next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StEmpty: if (push) state_d = StOne;
      StOne: begin
        if (push && !pop)      state_d = StFull;
        else if (!push && pop) state_d = StEmpty;
      end
      StFull:  if (pop) state_d = StOne;
      default: state_d = StEmpty;
    endcase
  end

  // Handshake outputs and entry-load controls from occupancy.
  always_comb begin
    in_ready       = rst_n & (state_q != StFull);
    out_valid      = (state_q != StEmpty);
    load_head_new  = 1'b0;
    load_head_tail = 1'b0;
    load_tail_new  = 1'b0;
    case (state_q)
      StEmpty: load_head_new = push;
      StOne: begin
        // Simultaneous push/pop: the new entry becomes the head directly.
        load_head_new = push & pop;
        load_tail_new = push & ~pop;
      end
      StFull:  load_head_tail = pop;
      default: ;
    endcase
  end

  // Entry storage; head drives the outputs so they hold while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (load_head_new)       head_q <= res;
      else if (load_head_tail) head_q <= tail_q;
      if (load_tail_new)       tail_q <= res;
    end
  end

  assign out_data = head_q.data;
  assign out_tag  = head_q.tag;
  assign out_err  = head_q.err;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed self-checking bench for imm_extend_unit (default parameters).
`timescale 1ns/1ps
module tb_imm_extend_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_mode;
  logic [31:0] in_data;
  logic [1:0]  in_off;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_extend_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .in_off    (in_off),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with an empty buffer and out_ready = 1.
  task automatic run_one(input string name, input logic [2:0] mode, input logic [31:0] data,
                         input logic [1:0] off, input logic [4:0] t,
                         input logic [31:0] exp_d, input logic exp_e);
    in_valid = 1'b1; in_mode = mode; in_data = data; in_off = off; in_tag = t;
    check({name, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check({name, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({name, ".data"},  out_data, exp_d);
    check({name, ".tag"},   {27'd0, out_tag}, {27'd0, t});
    check({name, ".err"},   {31'd0, out_err}, {31'd0, exp_e});
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_mode = 3'd0; in_data = '0; in_off = 2'd0;
    in_tag = '0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst.in_ready",  {31'd0, in_ready}, 32'd0);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.out_data",  out_data, 32'd0);
    check("rst.out_tag",   {27'd0, out_tag}, 32'd0);
    check("rst.out_err",   {31'd0, out_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rel.in_ready",  {31'd0, in_ready}, 32'd1);
    check("rel.out_valid", {31'd0, out_valid}, 32'd0);

    // Basic modes; upper input bits are junk to prove only imm is used.
    run_one("sign",  3'd1, 32'hABCD8001, 2'd3, 5'd3, 32'hFFFF8001, 1'b0);
    run_one("zero",  3'd0, 32'hABCD8001, 2'd1, 5'd4, 32'h00008001, 1'b0);
    run_one("upper", 3'd2, 32'h00001234, 2'd0, 5'd5, 32'h12340000, 1'b0);
    run_one("pass",  3'd3, 32'hDEADBEEF, 2'd2, 5'd6, 32'hDEADBEEF, 1'b0);
    run_one("signp", 3'd1, 32'h00007FFF, 2'd0, 5'd7, 32'h00007FFF, 1'b0);
    check("idle.out_valid", {31'd0, out_valid}, 32'd0);

`ifdef IMMEXT_LOAD_EN
    run_one("lb2",  3'd4, 32'h80FF7F01, 2'd2, 5'd8,  32'hFFFFFFFF, 1'b0);
    run_one("lb1",  3'd4, 32'h80FF7F01, 2'd1, 5'd9,  32'h0000007F, 1'b0);
    run_one("lbu3", 3'd5, 32'h80FF7F01, 2'd3, 5'd10, 32'h00000080, 1'b0);
    run_one("lh2",  3'd6, 32'h80FF7F01, 2'd2, 5'd11, 32'hFFFF80FF, 1'b0);
    run_one("lhu0", 3'd7, 32'h80FF7F01, 2'd0, 5'd12, 32'h00007F01, 1'b0);
    run_one("lhu2", 3'd7, 32'h80FF7F01, 2'd2, 5'd13, 32'h000080FF, 1'b0);
    run_one("lh1",  3'd6, 32'h80FF7F01, 2'd1, 5'd14, 32'h00000000, 1'b1);
    run_one("lhu3", 3'd7, 32'h80FF7F01, 2'd3, 5'd15, 32'h00000000, 1'b1);
`else
    run_one("nold4", 3'd4, 32'h80FF7F01, 2'd0, 5'd8,  32'h00000000, 1'b1);
    run_one("nold7", 3'd7, 32'h80FF7F01, 2'd0, 5'd9,  32'h00000000, 1'b1);
`endif

    // Back-pressure: three back-to-back requests, only two accepted.
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 3'd3; in_off = 2'd0;
    in_data = 32'h0000_0A0A; in_tag = 5'd10;
    check("bp.rdy0", {31'd0, in_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    in_data = 32'h0000_0B0B; in_tag = 5'd11;
    check("bp.rdy1", {31'd0, in_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    in_data = 32'h0000_0C0C; in_tag = 5'd12;
    check("bp.rdy2", {31'd0, in_ready}, 32'd0);
    check("bp.head_tag", {27'd0, out_tag}, 32'd10);
    @(posedge clk); @(negedge clk);
    check("bp.hold_data", out_data, 32'h0000_0A0A);
    check("bp.hold_rdy", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("bp.second_valid", {31'd0, out_valid}, 32'd1);
    check("bp.second_tag", {27'd0, out_tag}, 32'd11);
    check("bp.second_data", out_data, 32'h0000_0B0B);
    @(posedge clk); @(negedge clk);
    check("bp.drained", {31'd0, out_valid}, 32'd0);

    // Streaming: 100 requests, one result per cycle.
    in_mode = 3'd3;
    for (int i = 0; i <= 100; i++) begin
      if (i > 0) begin
        check("st.valid", {31'd0, out_valid}, 32'd1);
        check("st.data", out_data, 32'(i - 1));
        check("st.tag", {27'd0, out_tag}, {27'd0, 5'(i - 1)});
      end
      if (i < 100) begin
        in_valid = 1'b1; in_data = 32'(i); in_tag = 5'(i);
        check("st.in_ready", {31'd0, in_ready}, 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); @(negedge clk);
    end
    check("st.end_valid", {31'd0, out_valid}, 32'd0);

    // Reset while FULL flushes both entries.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1111; in_tag = 5'd1;
    @(posedge clk); @(negedge clk);
    in_data = 32'h2222; in_tag = 5'd2;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("full.in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check("frst.out_valid", {31'd0, out_valid}, 32'd0);
    check("frst.out_data", out_data, 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("frst.no_emit", {31'd0, out_valid}, 32'd0);
    check("frst.in_ready", {31'd0, in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
